// File: rtl/mmult_seq_if.sv
// mmult_seq_if: start/parameter inputs and operand strobes between
// pipeline control, the MMULT sequencer and the systolic MAC datapath.
interface mmult_seq_if #(
    parameter int STRIDE_W = 10
);
    logic                go;
    logic [3:0]          mwidth;
    logic [STRIDE_W-1:0] mtxaddr;
    logic                mtxcol;
    logic                hold;
    logic [STRIDE_W-1:0] maddr;
    logic                mrd;
    logic                macc_clr;
    logic                mlast;
    logic                busy;
    logic                done;

    modport master (
        output go, mwidth, mtxaddr, mtxcol, hold,
        input  maddr, mrd, macc_clr, mlast, busy, done
    );

    modport slave (
        input  go, mwidth, mtxaddr, mtxcol, hold,
        output maddr, mrd, macc_clr, mlast, busy, done
    );
endinterface

// File: rtl/mmult_seq.sv
// mmult_seq: MMULT sequencer. Walks N operand addresses with stride 1
// or N, then waits out the two-stage MAC pipeline before signalling done.
module mmult_seq #(
    parameter int STRIDE_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    mmult_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [STRIDE_W-1:0] ONE = {{(STRIDE_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [3:0]          cnt;
    logic [STRIDE_W-1:0] addr;
    logic [STRIDE_W-1:0] stride;
    logic                first;
    logic [1:0]          drain;

    // Sequencer state; hold freezes everything, reset wins over all
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr   <= '0;
            stride <= '0;
            first  <= 1'b0;
            drain  <= 2'd0;
        end else if (!bus.hold) begin
            unique case (state)
                IDLE: begin
                    if (bus.go) begin
                        cnt    <= bus.mwidth;
                        addr   <= bus.mtxaddr;
                        stride <= bus.mtxcol ? STRIDE_W'(bus.mwidth) : ONE;
                        first  <= 1'b1;
                        state  <= (bus.mwidth != 4'd0) ? RUN : FIN;
                    end
                end
                RUN: begin
                    first <= 1'b0;
                    cnt   <= cnt - 4'd1;
                    addr  <= addr + stride;
                    if (cnt == 4'd1) begin
                        state <= DRAIN;
                        drain <= 2'd2;
                    end
                end
                DRAIN: begin
                    drain <= drain - 2'd1;
                    if (drain == 2'd1) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from registered state and are gated off while held
    assign bus.maddr    = addr;
    assign bus.mrd      = (state == RUN) && !bus.hold;
    assign bus.macc_clr = (state == RUN) && first && !bus.hold;
    assign bus.mlast    = (state == RUN) && (cnt == 4'd1) && !bus.hold;
    assign bus.done     = (state == FIN) && !bus.hold;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_mmult_seq.sv
// tb_mmult_seq: scoreboard bench for the MMULT sequencer; expected
// per-cycle output vectors are queued per scenario and popped each cycle.
module tb_mmult_seq;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    // {busy, mrd, macc_clr, mlast, done, maddr-when-mrd}
    logic [14:0] exp_q[$];

    mmult_seq_if #(.STRIDE_W(10)) bus ();

    mmult_seq #(.STRIDE_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs of one run whose go lands on cycle 'start';
    // cycles flagged in 'holds' show busy only and push the rest out.
    function automatic void push_run(input logic [9:0] base, input int n,
                                     input bit col, input logic [31:0] holds,
                                     input int start);
        logic [14:0] u[$];
        logic [9:0]  a;
        logic [9:0]  st;
        int          c;
        int          idx;
        st = col ? 10'(n) : 10'd1;
        a  = base;
        if (n > 0) begin
            for (int i = 1; i <= n; i++) begin
                u.push_back({1'b1, 1'b1, (i == 1), (i == n), 1'b0, a});
                a = a + st;
            end
            u.push_back({5'b10000, 10'h000});
            u.push_back({5'b10000, 10'h000});
        end
        u.push_back({5'b10001, 10'h000});
        c   = start + 1;
        idx = 0;
        while (idx < u.size()) begin
            if (holds[c]) begin
                exp_q.push_back({5'b10000, 10'h000});
            end else begin
                exp_q.push_back(u[idx]);
                idx++;
            end
            c++;
        end
        exp_q.push_back(15'h0);
    endfunction

    task automatic set_params(input logic [9:0] base, input logic [3:0] n,
                              input bit col);
        bus.mtxaddr = base;
        bus.mwidth  = n;
        bus.mtxcol  = col;
    endtask

    // One clock cycle: apply go/hold, sample mid-cycle, step past the edge
    task automatic drive_cycle(input bit g, input bit h,
                               output logic [14:0] obs);
        bus.go   = g;
        bus.hold = h;
        #2;
        obs = {bus.busy, bus.mrd, bus.macc_clr, bus.mlast, bus.done,
               bus.mrd ? bus.maddr : 10'h000};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.go = 1'b1;
        bus.hold = 1'b0;
        set_params(10'h155, 4'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.mrd, bus.macc_clr, bus.mlast, bus.done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {bus.busy, bus.mrd, bus.macc_clr, bus.mlast, bus.done});
        end
        total++;
        if (bus.maddr !== 10'h000) begin
            bad++;
            $display("FAIL reset_maddr got=%h want=000", bus.maddr);
        end
        bus.go = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy got=%b want=0", bus.busy);
        end
    endtask

    task automatic test_row();
        logic [14:0] obs;
        logic [14:0] exp;
        int n;
        push_run(10'h100, 4, 1'b0, 32'h0, 0);
        n = exp_q.size();
        set_params(10'h100, 4'd4, 1'b0);
        for (int c = 0; c <= n; c++) begin
            drive_cycle(c == 0, 1'b0, obs);
            if (c >= 1) begin
                exp = exp_q.pop_front();
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL row c%0d got=%h want=%h", c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_col_wrap();
        logic [14:0] obs;
        logic [14:0] exp;
        int n;
        push_run(10'h3FE, 3, 1'b1, 32'h0, 0);
        n = exp_q.size();
        set_params(10'h3FE, 4'd3, 1'b1);
        for (int c = 0; c <= n; c++) begin
            drive_cycle(c == 0, 1'b0, obs);
            if (c == 1) set_params(10'h000, 4'd7, 1'b0);
            if (c >= 1) begin
                exp = exp_q.pop_front();
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL col_wrap c%0d got=%h want=%h", c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [14:0] obs;
        logic [14:0] exp;
        logic [31:0] holds;
        int n;
        holds = 32'b1100;
        push_run(10'h100, 4, 1'b0, holds, 0);
        n = exp_q.size();
        set_params(10'h100, 4'd4, 1'b0);
        for (int c = 0; c <= n; c++) begin
            drive_cycle(c == 0, holds[c], obs);
            if (c >= 1) begin
                exp = exp_q.pop_front();
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL hold c%0d got=%h want=%h", c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_edge_widths();
        logic [14:0] obs;
        logic [14:0] exp;
        int n;
        push_run(10'h2A0, 1, 1'b0, 32'h0, 0);
        push_run(10'h050, 0, 1'b0, 32'h0, 5);
        n = exp_q.size();
        for (int c = 0; c <= n; c++) begin
            if (c == 0) set_params(10'h2A0, 4'd1, 1'b0);
            if (c == 5) set_params(10'h050, 4'd0, 1'b1);
            drive_cycle(c == 0 || c == 5, 1'b0, obs);
            if (c >= 1) begin
                exp = exp_q.pop_front();
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL edge_width c%0d got=%h want=%h", c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] obs;
        logic [14:0] exp;
        int n;
        push_run(10'h100, 4, 1'b0, 32'h0, 0);
        push_run(10'h200, 2, 1'b1, 32'h0, 8);
        n = exp_q.size();
        for (int c = 0; c <= n; c++) begin
            if (c == 0) set_params(10'h100, 4'd4, 1'b0);
            else if (c <= 5) set_params(10'h3FF, 4'd9, 1'b1);
            else if (c == 8) set_params(10'h200, 4'd2, 1'b1);
            drive_cycle(c <= 5 || c == 8, 1'b0, obs);
            if (c >= 1) begin
                exp = exp_q.pop_front();
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL back_to_back c%0d got=%h want=%h", c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] obs;
        set_params(10'h100, 4'd4, 1'b0);
        drive_cycle(1'b1, 1'b0, obs);
        drive_cycle(1'b0, 1'b0, obs);
        reset = 1'b1;
        drive_cycle(1'b0, 1'b0, obs);
        reset = 1'b0;
        bus.go = 1'b0;
        #2;
        total++;
        if (bus.busy !== 1'b0 || bus.maddr !== 10'h000) begin
            bad++;
            $display("FAIL reset_mid c3 got busy=%b maddr=%h want busy=0 maddr=000",
                     bus.busy, bus.maddr);
        end
        @(posedge clk);
        #1;
        for (int c = 4; c <= 10; c++) begin
            drive_cycle(1'b0, 1'b0, obs);
            total++;
            if (obs !== 15'h0) begin
                bad++;
                $display("FAIL reset_mid_quiet c%0d got=%h want=0000", c, obs);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.go = 1'b0;
        bus.hold = 1'b0;
        bus.mwidth = 4'd0;
        bus.mtxaddr = 10'h000;
        bus.mtxcol = 1'b0;
        test_reset();
        test_row();
        test_col_wrap();
        test_hold();
        test_edge_widths();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
